// File: rtl/host_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// tpu_host_pkg
// Shared definitions for the host-to-TPU ingress loader.
//   - header field bit positions
//   - opcode values carried in the header
//   - loader FSM state encoding
//   - decode_opcode(): classifies a header opcode field
// ----------------------------------------------------------------------------
package tpu_host_pkg;

    // Header layout: [31:28] opcode, [27:20] burst length - 1, [ADDR_W-1:0] start address
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int LEN_MSB = 27;
    localparam int LEN_LSB = 20;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_WRITE = 4'h1,
        OP_START = 4'h2
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } loader_state_e;

    // Collapses the 16 possible opcode encodings into the four actions the
    // loader distinguishes; every unlisted encoding is illegal.
    typedef enum logic [1:0] {
        HDR_NOP,
        HDR_WRITE,
        HDR_START,
        HDR_ILLEGAL
    } hdr_kind_e;

    function automatic hdr_kind_e decode_opcode(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_NOP:   return HDR_NOP;
            OP_WRITE: return HDR_WRITE;
            OP_START: return HDR_START;
            default:  return HDR_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/host_mem_loader_if.sv
// ----------------------------------------------------------------------------
// host_mem_loader_if
// Bundles the host word stream (valid/ready/data) and the unified memory
// write port (gnt/we/addr/wdata) seen by the loader.
//   slave  : the loader's view (consumes host words, drives memory writes)
//   master : the environment's view (host + memory arbiter)
// ----------------------------------------------------------------------------
interface host_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              host_valid;
    logic              host_ready;
    logic [DATA_W-1:0] host_data;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  host_valid, host_data, mem_gnt,
        output host_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output host_valid, host_data, mem_gnt,
        input  host_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/host_mem_loader.sv
// ----------------------------------------------------------------------------
// host_mem_loader
// Decodes a 32-bit host word stream into command frames. WRITE frames copy
// their payload into unified memory through the arbitrated write port, START
// emits a one-cycle kick to the TPU core, NOP is ignored and anything else
// raises a sticky error.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   bus           host stream + memory write port (slave modport)
//   load_done     one-cycle pulse together with the last payload write
//   tpu_start     one-cycle pulse following a START header
//   busy          high while a WRITE payload is being transferred
//   err           sticky illegal-opcode flag
//   words_written saturating count of payload words written
// ----------------------------------------------------------------------------
module host_mem_loader
    import tpu_host_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    host_mem_loader_if.slave    bus,
    output logic                load_done,
    output logic                tpu_start,
    output logic                busy,
    output logic                err,
    output logic [15:0]         words_written
);

    localparam int             REM_W   = LEN_W + 1;
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    loader_state_e     r_state;
    logic              r_ready_en;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remaining;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_load_done;
    logic              r_tpu_start;
    logic              r_err;
    logic [15:0]       r_words;

    logic              w_host_ready;
    logic              w_hs;
    logic [OPC_W-1:0]  w_opc;
    logic [LEN_W-1:0]  w_hdr_len;
    logic [ADDR_W-1:0] w_hdr_addr;
    hdr_kind_e         w_kind;

    // r_ready_en keeps host_ready low while reset is held and lets it rise
    // on the first clock edge after release. In DATA, the arbiter grant
    // gates acceptance so a word is only taken when it can be written.
    assign w_host_ready = (r_state == ST_DATA) ? bus.mem_gnt : r_ready_en;
    assign w_hs         = bus.host_valid & w_host_ready;

    assign w_opc      = bus.host_data[OPC_MSB:OPC_LSB];
    assign w_hdr_len  = bus.host_data[LEN_LSB +: LEN_W];
    assign w_hdr_addr = bus.host_data[ADDR_W-1:0];
    assign w_kind     = decode_opcode(w_opc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready_en  <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_done <= 1'b0;
            r_tpu_start <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            r_ready_en  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;
            r_tpu_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        case (w_kind)
                            HDR_WRITE: begin
                                r_addr      <= w_hdr_addr;
                                r_remaining <= {1'b0, w_hdr_len} + REM_ONE;
                                r_state     <= ST_DATA;
                            end
                            HDR_START:   r_tpu_start <= 1'b1;
                            HDR_ILLEGAL: r_err       <= 1'b1;
                            default: ;
                        endcase
                    end
                end

                ST_DATA: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= bus.host_data;
                        // Address wraps naturally at the top of memory.
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_words != 16'hFFFF) begin
                            r_words <= r_words + 16'd1;
                        end
                        // Returning to IDLE here lets the very next word be
                        // taken as a header, so frames chain without a gap.
                        if (r_remaining == REM_ONE) begin
                            r_state     <= ST_IDLE;
                            r_load_done <= 1'b1;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.host_ready = w_host_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign load_done      = r_load_done;
    assign tpu_start      = r_tpu_start;
    assign busy           = (r_state == ST_DATA);
    assign err            = r_err;
    assign words_written  = r_words;

endmodule

// File: tb/tb_host_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_host_mem_loader
// Drives framed host traffic into host_mem_loader and compares the observed
// memory writes, load_done/tpu_start pulses and status outputs against a
// frame-level reference model kept in this bench.
// ----------------------------------------------------------------------------
module tb_host_mem_loader;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_done;
    logic        tpu_start;
    logic        busy;
    logic        err;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    wr_t         exp_wr[$];
    int          exp_done[$];
    int          exp_start[$];
    logic        exp_err;
    int          exp_words;
    // Observations
    wr_t         obs_wr[$];
    int          obs_done[$];
    int          obs_start[$];

    logic [31:0] payload_q[$];
    bit          gnt_rand = 1'b0;
    bit          gaps     = 1'b0;

    host_mem_loader_if bus ();

    host_mem_loader dut (
        .clk           (clk),
        .reset         (rst_n),
        .bus           (bus),
        .load_done     (load_done),
        .tpu_start     (tpu_start),
        .busy          (busy),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we) obs_wr.push_back('{bus.mem_addr, bus.mem_wdata, 32'(cyc)});
        if (load_done)  obs_done.push_back(cyc);
        if (tpu_start)  obs_start.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers and model ----------------
    // resp_cyc is the cycle in which the DUT's registered response to the
    // accepted word becomes visible (the cycle right after the handshake).
    task automatic drive_word(input logic [31:0] w, output int resp_cyc);
        bit done = 1'b0;
        resp_cyc = -1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            bus.mem_gnt    = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.host_valid = 1'b1;
            bus.host_data  = w;
            #1;
            if (bus.host_ready) begin
                resp_cyc = cyc + 1;
                done     = 1'b1;
                @(posedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: word %h not accepted, required acceptance within 200 cycles", w);
        end
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.host_valid = 1'b0;
        end
    endtask

    task automatic model_write(input int a, input logic [31:0] d, input int rc);
        exp_wr.push_back('{6'(a % 64), d, 32'(rc)});
        if (exp_words < 65535) exp_words++;
    endtask

    // Sends a WRITE header plus payload_q; payload word i lands at (a+i) mod 64.
    task automatic send_write_frame(input int a, input logic [13:0] junk,
                                    output int first_rc, output int last_rc);
        int rc;
        int len = payload_q.size() - 1;
        drive_word({4'h1, 8'(len), junk, 6'(a)}, rc);
        first_rc = rc;
        for (int i = 0; i < payload_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.host_valid = 1'b0;
            end
            drive_word(payload_q[i], rc);
            model_write(a + i, payload_q[i], rc);
        end
        last_rc = rc;
        exp_done.push_back(rc);
    endtask

    task automatic send_cmd(input logic [31:0] w);
        int rc;
        drive_word(w, rc);
        if (w[31:28] == 4'h2) exp_start.push_back(rc);
        else if (w[31:28] > 4'h2) exp_err = 1'b1;
    endtask

    task automatic clear_logs();
        exp_wr.delete();  obs_wr.delete();
        exp_done.delete(); obs_done.delete();
        exp_start.delete(); obs_start.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.host_valid = 1'b0; bus.host_data = '0; bus.mem_gnt = 1'b0;
        exp_err = 1'b0; exp_words = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.host_ready, bus.mem_we, busy, err, load_done, tpu_start} !== 6'b0 || words_written !== 16'd0
            || bus.mem_addr !== 6'd0 || bus.mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b err=%b done=%b start=%b words=%0d, required all 0",
                     bus.host_ready, bus.mem_we, busy, err, load_done, tpu_start, words_written);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.host_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b required 0", bus.host_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.host_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got rdy=%b busy=%b required rdy=1 busy=0", bus.host_ready, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_write();
        int f, l;
        clear_logs();
        gnt_rand = 1'b0; gaps = 1'b0;
        payload_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        send_write_frame(4, 14'h0, f, l);
        go_idle(3);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != 1) begin
            errors++;
            $display("FAIL basic_counts: got writes=%0d done=%0d, required writes=%0d done=1",
                     obs_wr.size(), obs_done.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL basic_wr[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
            end
        end
        checks++;
        if (obs_done.size() > 0 && obs_done[0] != exp_done[0]) begin
            errors++;
            $display("FAIL basic_load_done_cycle: got %0d required %0d", obs_done[0], exp_done[0]);
        end
        checks++;
        if (words_written !== 16'(exp_words) || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got words=%0d busy=%b, required words=%0d busy=0", words_written, busy, exp_words);
        end
        $display("test_basic_write done: %0d writes", obs_wr.size());
    endtask

    task automatic test_wrap();
        int f, l;
        clear_logs();
        payload_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_write_frame(62, 14'h155A, f, l);
        go_idle(3);
        checks++;
        if (obs_wr.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes required 4", obs_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL wrap_wr[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_stall();
        int rc;
        clear_logs();
        drive_word({4'h1, 8'd1, 14'h0, 6'd0}, rc);
        drive_word(32'hCAFE_0001, rc);
        model_write(0, 32'hCAFE_0001, rc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.host_valid = 1'b1; bus.host_data = 32'hCAFE_0002;
            #1;
            checks++;
            if (bus.host_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got rdy=%b busy=%b required rdy=0 busy=1", i, bus.host_ready, busy);
            end
        end
        drive_word(32'hCAFE_0002, rc);
        model_write(1, 32'hCAFE_0002, rc);
        exp_done.push_back(rc);
        go_idle(3);
        checks++;
        if (obs_wr.size() != 2 || obs_done.size() != 1) begin
            errors++;
            $display("FAIL stall_counts: got writes=%0d done=%0d required writes=2 done=1", obs_wr.size(), obs_done.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL stall_wr[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_start_illegal();
        int f, l;
        clear_logs();
        send_cmd(32'h2000_0000);
        send_cmd(32'h0ABC_DEF0);
        send_cmd(32'hF000_0000);
        go_idle(2);
        checks++;
        if (obs_start.size() != 1 || (obs_start.size() == 1 && obs_start[0] != exp_start[0])) begin
            errors++;
            $display("FAIL start_pulse: got %0d pulses (first cyc %0d), required 1 pulse at cyc %0d",
                     obs_start.size(), obs_start.size() ? obs_start[0] : -1, exp_start[0]);
        end
        checks++;
        if (obs_wr.size() != 0 || err !== exp_err) begin
            errors++;
            $display("FAIL illegal_err: got writes=%0d err=%b required writes=0 err=%b", obs_wr.size(), err, exp_err);
        end
        payload_q = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002};
        send_write_frame(30, 14'h3FFF, f, l);
        go_idle(3);
        checks++;
        if (obs_wr.size() != exp_wr.size() || err !== 1'b1 || obs_done.size() != 1) begin
            errors++;
            $display("FAIL post_err_write: got writes=%0d err=%b done=%0d required writes=%0d err=1 done=1",
                     obs_wr.size(), err, obs_done.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL post_err_wr[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                         i, obs_wr[i].addr, obs_wr[i].data, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        $display("test_start_illegal done");
    endtask

    task automatic test_reset_mid_burst();
        int rc, f, l;
        clear_logs();
        drive_word({4'h1, 8'd7, 14'h0, 6'd10}, rc);
        for (int i = 0; i < 3; i++) begin
            drive_word(32'hBEEF_0000 + i, rc);
            model_write(10 + i, 32'hBEEF_0000 + i, rc);
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        checks++;
        if (words_written !== 16'(exp_words) || busy !== 1'b1) begin
            errors++;
            $display("FAIL midburst_pre: got words=%0d busy=%b required words=%0d busy=1", words_written, busy, exp_words);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_err = 1'b0; exp_words = 0;
        checks++;
        if (busy !== 1'b0 || bus.mem_we !== 1'b0 || err !== 1'b0 || words_written !== 16'd0 || bus.host_ready !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: got busy=%b we=%b err=%b words=%0d rdy=%b required all 0",
                     busy, bus.mem_we, err, words_written, bus.host_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        payload_q = '{32'h7777_0001, 32'h7777_0002};
        send_write_frame(20, 14'h0, f, l);
        go_idle(3);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != 1) begin
            errors++;
            $display("FAIL midburst_counts: got writes=%0d done=%0d required writes=%0d done=1",
                     obs_wr.size(), obs_done.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL midburst_wr[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
            end
        end
        checks++;
        if (words_written !== 16'(exp_words)) begin
            errors++;
            $display("FAIL midburst_words: got %0d required %0d", words_written, exp_words);
        end
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
        clear_logs();
        gnt_rand = 1'b0; gaps = 1'b0;
        payload_q = '{32'h11};
        send_write_frame(5, 14'h0, f1, l1);
        payload_q = '{32'h22};
        send_write_frame(9, 14'h0, f2, l2);
        go_idle(3);
        checks++;
        if (l2 - f1 != 3) begin
            errors++;
            $display("FAIL b2b_handshakes: 4 words took %0d cycles, required 4 (no bubble)", l2 - f1 + 1);
        end
        checks++;
        if (obs_wr.size() != 2 || obs_done.size() != 2) begin
            errors++;
            $display("FAIL b2b_counts: got writes=%0d done=%0d required writes=2 done=2", obs_wr.size(), obs_done.size());
        end else begin
            checks++;
            if (obs_wr[0] !== exp_wr[0] || obs_wr[1] !== exp_wr[1] || obs_wr[1].cyc - obs_wr[0].cyc != 2) begin
                errors++;
                $display("FAIL b2b_writes: got (%0d,%h,c%0d) (%0d,%h,c%0d) required (%0d,%h,c%0d) (%0d,%h,c%0d)",
                         obs_wr[0].addr, obs_wr[0].data, obs_wr[0].cyc, obs_wr[1].addr, obs_wr[1].data, obs_wr[1].cyc,
                         exp_wr[0].addr, exp_wr[0].data, exp_wr[0].cyc, exp_wr[1].addr, exp_wr[1].data, exp_wr[1].cyc);
            end
            checks++;
            if (obs_done[0] != exp_done[0] || obs_done[1] != exp_done[1]) begin
                errors++;
                $display("FAIL b2b_done: got cyc %0d,%0d required %0d,%0d", obs_done[0], obs_done[1], exp_done[0], exp_done[1]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int f, l, a, len;
        clear_logs();
        gnt_rand = 1'b1; gaps = 1'b1;
        for (int fr = 0; fr < 12; fr++) begin
            case ($urandom_range(0, 5))
                0: send_cmd({4'h2, 28'($urandom)});
                1: send_cmd({4'h0, 28'($urandom)});
                default: begin
                    a   = $urandom_range(0, 63);
                    len = $urandom_range(0, 15);
                    payload_q.delete();
                    for (int i = 0; i <= len; i++) payload_q.push_back($urandom);
                    send_write_frame(a, 14'($urandom), f, l);
                end
            endcase
        end
        go_idle(3);
        gnt_rand = 1'b0; gaps = 1'b0;
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != exp_done.size() || obs_start.size() != exp_start.size()) begin
            errors++;
            $display("FAIL random_counts: got writes=%0d done=%0d start=%0d required %0d %0d %0d",
                     obs_wr.size(), obs_done.size(), obs_start.size(), exp_wr.size(), exp_done.size(), exp_start.size());
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL random_wr[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
            end
        end
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
            checks++;
            if (obs_done[i] != exp_done[i]) begin
                errors++;
                $display("FAIL random_done[%0d]: got cyc %0d required %0d", i, obs_done[i], exp_done[i]);
            end
        end
        checks++;
        if (words_written !== 16'(exp_words) || err !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_status: got words=%0d err=%b busy=%b required words=%0d err=%b busy=0",
                     words_written, err, busy, exp_words, exp_err);
        end
        $display("test_random done: %0d writes", obs_wr.size());
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrap();
        test_stall();
        test_start_illegal();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
